// File: rtl/fir_tdm_mc_pkg.sv
// Shared configuration, state encoding and output round/saturate helper
// for the time-multiplexed multi-channel FIR.
package fir_tdm_pkg;
    localparam int DATA_W    = 24;
    localparam int COEF_W    = 32;
    localparam int TAPS      = 64;
    localparam int CHANNELS  = 2;
    localparam int FRAC_BITS = 24;

    localparam int CW     = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
    localparam int AW     = $clog2(TAPS);
    localparam int PROD_W = DATA_W + COEF_W;
    localparam int ACC_W  = PROD_W + $clog2(TAPS);

    localparam logic signed [ACC_W-1:0] RND_HALF = ACC_W'(1) << (FRAC_BITS - 1);
    localparam logic signed [ACC_W-1:0] SAT_MAX  = {{(ACC_W-DATA_W+1){1'b0}}, {(DATA_W-1){1'b1}}};
    localparam logic signed [ACC_W-1:0] SAT_MIN  = {{(ACC_W-DATA_W+1){1'b1}}, {(DATA_W-1){1'b0}}};

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MAC  = 2'd1,
        ST_RND  = 2'd2,
        ST_OUT  = 2'd3
    } state_t;

    typedef struct packed {
        logic signed [DATA_W-1:0] data;
        logic                     sat;
    } rs_t;

    // Round half toward +inf, arithmetic shift, then clamp to the sample range.
    function automatic rs_t round_sat(input logic signed [ACC_W-1:0] acc);
        rs_t                     res;
        logic signed [ACC_W-1:0] r;
        r       = (acc + RND_HALF) >>> FRAC_BITS;
        res.sat = 1'b1;
        if (r > SAT_MAX) begin
            res.data = SAT_MAX[DATA_W-1:0];
        end else if (r < SAT_MIN) begin
            res.data = SAT_MIN[DATA_W-1:0];
        end else begin
            res.data = r[DATA_W-1:0];
            res.sat  = 1'b0;
        end
        return res;
    endfunction
endpackage

// File: rtl/fir_tdm_mc_if.sv
// Sample-in, sample-out and coefficient-write signals of the TDM FIR.
interface fir_tdm_mc_if;
    import fir_tdm_pkg::*;

    logic                     in_valid;
    logic                     in_ready;
    logic signed [DATA_W-1:0] in_data;
    logic [CW-1:0]            in_chan;
    logic                     out_valid;
    logic                     out_ready;
    logic signed [DATA_W-1:0] out_data;
    logic [CW-1:0]            out_chan;
    logic                     out_sat;
    logic                     coef_we;
    logic [AW-1:0]            coef_addr;
    logic signed [COEF_W-1:0] coef_data;
    logic                     coef_busy;

    modport master (
        output in_valid, in_data, in_chan, out_ready, coef_we, coef_addr, coef_data,
        input  in_ready, out_valid, out_data, out_chan, out_sat, coef_busy
    );

    modport slave (
        input  in_valid, in_data, in_chan, out_ready, coef_we, coef_addr, coef_data,
        output in_ready, out_valid, out_data, out_chan, out_sat, coef_busy
    );
endinterface

// File: rtl/fir_tdm_mc_hist_ram.sv
// Per-channel sample history, addressed {ch, idx}, one write and one registered read port.
// A resettable written-bitmap makes never-written entries read as zero after reset.
module fir_hist_ram
    import fir_tdm_pkg::*;
(
    input  logic                     i_clk,
    input  logic                     i_rst,
    input  logic                     i_we,
    input  logic [CW+AW-1:0]         i_waddr,
    input  logic signed [DATA_W-1:0] i_wdata,
    input  logic                     i_re,
    input  logic [CW+AW-1:0]         i_raddr,
    output logic signed [DATA_W-1:0] o_rdata
);
    localparam int DEPTH = 1 << (CW + AW);

    logic signed [DATA_W-1:0] r_mem [DEPTH];
    logic signed [DATA_W-1:0] r_rdata;
    logic [DEPTH-1:0]         r_written;
    logic                     r_rd_written;

    always_ff @(posedge i_clk) begin
        if (i_we) r_mem[i_waddr] <= i_wdata;
        if (i_re) r_rdata <= r_mem[i_raddr];
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_written    <= '0;
            r_rd_written <= 1'b0;
        end else begin
            if (i_we) r_written[i_waddr] <= 1'b1;
            if (i_re) r_rd_written <= r_written[i_raddr];
        end
    end

    assign o_rdata = r_rd_written ? r_rdata : '0;
endmodule

// File: rtl/fir_tdm_mc.sv
// Time-multiplexed multi-channel FIR: one multiplier, one accumulator, TAPS MAC steps per sample.
//   state | meaning
//   IDLE  | ready for a sample; coefficient writes accepted
//   MAC   | TAPS reads + one drain cycle for the registered history read
//   RND   | round/saturate accumulator into output registers
//   OUT   | out_valid high until downstream accepts
module fir_tdm_mc
    import fir_tdm_pkg::*;
(
    input  logic        i_clk,
    input  logic        i_rst,
    fir_tdm_mc_if.slave io_bus
);
    state_t                   r_state, w_state_nxt;
    logic                     w_in_ready, w_out_valid, w_coef_busy;
    logic                     w_chan_ok, w_accept, w_coef_wr, w_rd_en, w_mac_last;
    logic [CW-1:0]            w_wr_ch;
    logic [CW-1:0]            r_ch;
    logic [AW:0]              r_k;
    logic [AW-1:0]            r_wp [CHANNELS];
    logic [AW-1:0]            w_wp_cur, w_rd_idx;
    logic [AW:0]              w_wp_ext, w_rd_sum;
    logic signed [COEF_W-1:0] r_coef_mem [TAPS];
    logic signed [COEF_W-1:0] r_coef;
    logic                     r_rd_vld;
    logic signed [ACC_W-1:0]  r_acc;
    logic signed [DATA_W-1:0] w_rdata;
    logic signed [PROD_W-1:0] w_prod;
    logic signed [DATA_W-1:0] r_out_data;
    logic [CW-1:0]            r_out_chan;
    logic                     r_out_sat;
    rs_t                      w_rs;

    generate
        if (CHANNELS == (1 << CW)) begin : g_chan_full
            assign w_chan_ok = 1'b1;
        end else begin : g_chan_part
            assign w_chan_ok = (int'(io_bus.in_chan) < CHANNELS);
        end
    endgenerate

    assign w_accept   = (r_state == ST_IDLE) && io_bus.in_valid && w_chan_ok;
    assign w_coef_wr  = (r_state == ST_IDLE) && io_bus.coef_we;
    assign w_wr_ch    = w_chan_ok ? io_bus.in_chan : '0;
    assign w_rd_en    = (r_state == ST_MAC) && (r_k < (AW+1)'(TAPS));
    assign w_mac_last = (r_state == ST_MAC) && (r_k == (AW+1)'(TAPS));

    // Tap k reads the sample written k inputs ago: (wp - k) mod TAPS.
    assign w_wp_cur = r_wp[r_ch];
    assign w_wp_ext = {1'b0, w_wp_cur};
    assign w_rd_sum = (w_wp_ext >= r_k) ? (w_wp_ext - r_k) : (w_wp_ext + (AW+1)'(TAPS) - r_k);
    assign w_rd_idx = AW'(w_rd_sum);

    fir_hist_ram u_hist (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .i_we    (w_accept),
        .i_waddr ({w_wr_ch, r_wp[w_wr_ch]}),
        .i_wdata (io_bus.in_data),
        .i_re    (w_rd_en),
        .i_raddr ({r_ch, w_rd_idx}),
        .o_rdata (w_rdata)
    );

    assign w_prod = PROD_W'(w_rdata) * PROD_W'(r_coef);
    assign w_rs   = round_sat(r_acc);

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) r_state <= ST_IDLE;
        else       r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        w_in_ready  = 1'b0;
        w_out_valid = 1'b0;
        w_coef_busy = 1'b1;
        case (r_state)
            ST_IDLE: begin
                w_in_ready  = 1'b1;
                w_coef_busy = 1'b0;
                if (w_accept) w_state_nxt = ST_MAC;
            end
            ST_MAC:  if (w_mac_last) w_state_nxt = ST_RND;
            ST_RND:  w_state_nxt = ST_OUT;
            ST_OUT: begin
                w_out_valid = 1'b1;
                if (io_bus.out_ready) w_state_nxt = ST_IDLE;
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_ch       <= '0;
            r_k        <= '0;
            r_coef     <= '0;
            r_rd_vld   <= 1'b0;
            r_acc      <= '0;
            r_out_data <= '0;
            r_out_chan <= '0;
            r_out_sat  <= 1'b0;
            for (int c = 0; c < CHANNELS; c++) r_wp[c] <= '0;
        end else begin
            r_rd_vld <= w_rd_en;
            if (w_accept) begin
                r_ch  <= w_wr_ch;
                r_k   <= '0;
                r_acc <= '0;
            end else begin
                if (r_state == ST_MAC) r_k <= r_k + 1'b1;
                if (r_rd_vld) r_acc <= r_acc + ACC_W'(w_prod);
            end
            if (w_rd_en) r_coef <= r_coef_mem[r_k[AW-1:0]];
            if (w_mac_last) r_wp[r_ch] <= (r_wp[r_ch] == AW'(TAPS - 1)) ? '0 : r_wp[r_ch] + 1'b1;
            if (r_state == ST_RND) begin
                r_out_data <= w_rs.data;
                r_out_chan <= r_ch;
                r_out_sat  <= w_rs.sat;
            end
        end
    end

    // A write in the same IDLE cycle as an accept lands before tap 0 is fetched.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            for (int t = 0; t < TAPS; t++) r_coef_mem[t] <= '0;
        end else if (w_coef_wr) begin
            r_coef_mem[io_bus.coef_addr] <= io_bus.coef_data;
        end
    end

    assign io_bus.in_ready  = w_in_ready;
    assign io_bus.out_valid = w_out_valid;
    assign io_bus.coef_busy = w_coef_busy;
    assign io_bus.out_data  = r_out_data;
    assign io_bus.out_chan  = r_out_chan;
    assign io_bus.out_sat   = r_out_sat;
endmodule

// File: tb/tb_fir_tdm_mc.sv
// Directed bench for fir_tdm_mc: vector tables plus hand-written backpressure,
// coefficient-timing and reset-abort sequences.
module tb_fir_tdm_mc;
    import fir_tdm_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_checks = 0;
    int   n_errors = 0;
    int   lat;
    int   seen;

    fir_tdm_mc_if bus();

    fir_tdm_mc dut (
        .i_clk  (clk),
        .i_rst  (rst),
        .io_bus (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        int ch;
        int din;
        int exp_d;
        bit exp_s;
    } vec_t;

    vec_t vecs[$];

    task automatic chk(input string name, input longint act, input longint exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst           = 1'b1;
        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.in_chan   = '0;
        bus.out_ready = 1'b1;
        bus.coef_we   = 1'b0;
        bus.coef_addr = '0;
        bus.coef_data = '0;
        tick();
        tick();
        rst = 1'b0;
        tick();
    endtask

    task automatic write_coef(input int addr, input longint val);
        bus.coef_we   = 1'b1;
        bus.coef_addr = AW'(addr);
        bus.coef_data = COEF_W'(val);
        tick();
        bus.coef_we   = 1'b0;
    endtask

    task automatic start_in(input string name, input int ch, input int din);
        chk({name, " in_ready"}, longint'(bus.in_ready), 1);
        bus.in_valid = 1'b1;
        bus.in_chan  = CW'(ch);
        bus.in_data  = DATA_W'(din);
        tick();
        bus.in_valid = 1'b0;
    endtask

    task automatic wait_out(input int start, output int cnt);
        cnt = start;
        while (!bus.out_valid && cnt < TAPS + 20) begin
            tick();
            cnt++;
        end
    endtask

    task automatic check_out(input string name, input int exp_d, input int exp_ch,
                             input bit exp_s, input int cnt);
        chk({name, " latency"}, cnt, TAPS + 2);
        chk({name, " out_data"}, longint'(bus.out_data), exp_d);
        chk({name, " out_chan"}, longint'(bus.out_chan), exp_ch);
        chk({name, " out_sat"}, longint'(bus.out_sat), longint'(exp_s));
        tick();
    endtask

    task automatic run_vecs(input string name);
        int l;
        for (int i = 0; i < vecs.size(); i++) begin
            start_in($sformatf("%s[%0d]", name, i), vecs[i].ch, vecs[i].din);
            wait_out(0, l);
            check_out($sformatf("%s[%0d]", name, i), vecs[i].exp_d, vecs[i].ch, vecs[i].exp_s, l);
        end
        vecs.delete();
    endtask

    task automatic set_ramp();
        for (int k = 0; k < TAPS; k++) write_coef(k, longint'(k + 1) << 24);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        do_reset();
        chk("reset in_ready", longint'(bus.in_ready), 1);
        chk("reset out_valid", longint'(bus.out_valid), 0);
        chk("reset out_data", longint'(bus.out_data), 0);
        chk("reset out_chan", longint'(bus.out_chan), 0);
        chk("reset out_sat", longint'(bus.out_sat), 0);
        chk("reset coef_busy", longint'(bus.coef_busy), 0);

        // Impulse through a ramp of coefficients: n-th output equals n+1.
        set_ramp();
        for (int n = 0; n < TAPS; n++) begin
            start_in($sformatf("impulse[%0d]", n), 0, (n == 0) ? 1 : 0);
            wait_out(0, lat);
            check_out($sformatf("impulse[%0d]", n), n + 1, 0, 1'b0, lat);
        end

        // Channel isolation: y = 2*x[n] + x[n-1], per channel.
        do_reset();
        write_coef(0, 64'd2 << 24);
        write_coef(1, 64'd1 << 24);
        vecs.push_back('{0, 100, 200, 1'b0});
        vecs.push_back('{1, 7, 14, 1'b0});
        vecs.push_back('{1, 0, 7, 1'b0});
        vecs.push_back('{0, 0, 100, 1'b0});
        vecs.push_back('{0, -5, -10, 1'b0});
        vecs.push_back('{1, -3, -6, 1'b0});
        run_vecs("isolation");

        // Saturation with all taps at 1.0.
        do_reset();
        for (int k = 0; k < TAPS; k++) write_coef(k, 64'd1 << 24);
        vecs.push_back('{0, 8388607, 8388607, 1'b0});
        vecs.push_back('{0, 8388607, 8388607, 1'b1});
        vecs.push_back('{1, -8388608, -8388608, 1'b0});
        vecs.push_back('{1, -8388608, -8388608, 1'b1});
        run_vecs("saturation");

        // Rounding with a single 0.5 tap.
        do_reset();
        write_coef(0, 64'd1 << 23);
        vecs.push_back('{0, 3, 2, 1'b0});
        vecs.push_back('{0, -3, -1, 1'b0});
        vecs.push_back('{0, 1, 1, 1'b0});
        vecs.push_back('{0, -1, 0, 1'b0});
        vecs.push_back('{1, 2, 1, 1'b0});
        run_vecs("rounding");

        // Backpressure: outputs held while out_ready is low.
        do_reset();
        write_coef(0, 64'd1 << 24);
        bus.out_ready = 1'b0;
        start_in("bp", 0, 42);
        wait_out(0, lat);
        chk("bp latency", lat, TAPS + 2);
        for (int i = 0; i < 10; i++) begin
            tick();
            chk("bp hold out_valid", longint'(bus.out_valid), 1);
            chk("bp hold out_data", longint'(bus.out_data), 42);
            chk("bp hold out_chan", longint'(bus.out_chan), 0);
            chk("bp hold in_ready", longint'(bus.in_ready), 0);
            chk("bp hold coef_busy", longint'(bus.coef_busy), 1);
        end
        bus.out_ready = 1'b1;
        tick();
        chk("bp release out_valid", longint'(bus.out_valid), 0);
        chk("bp release in_ready", longint'(bus.in_ready), 1);

        // Coefficient write during MAC is dropped.
        start_in("mac_we", 1, 10);
        bus.coef_we   = 1'b1;
        bus.coef_addr = '0;
        bus.coef_data = COEF_W'(64'd5 << 24);
        tick();
        bus.coef_we   = 1'b0;
        wait_out(1, lat);
        check_out("mac_we", 10, 1, 1'b0, lat);
        start_in("mac_we_after", 1, 3);
        wait_out(0, lat);
        check_out("mac_we_after", 3, 1, 1'b0, lat);

        // Coefficient write in the accept cycle applies to that sample.
        bus.coef_we   = 1'b1;
        bus.coef_addr = '0;
        bus.coef_data = COEF_W'(64'd3 << 24);
        start_in("same_cycle_we", 0, 4);
        bus.coef_we   = 1'b0;
        wait_out(0, lat);
        check_out("same_cycle_we", 12, 0, 1'b0, lat);

        // Reset in the middle of MAC aborts the sample and clears history.
        do_reset();
        set_ramp();
        start_in("pre_abort", 0, 5);
        wait_out(0, lat);
        check_out("pre_abort", 5, 0, 1'b0, lat);
        start_in("abort", 0, 9);
        for (int i = 0; i < 30; i++) tick();
        rst = 1'b1;
        #1;
        chk("abort out_valid", longint'(bus.out_valid), 0);
        tick();
        rst = 1'b0;
        tick();
        chk("abort in_ready", longint'(bus.in_ready), 1);
        chk("abort coef_busy", longint'(bus.coef_busy), 0);
        seen = 0;
        for (int i = 0; i < TAPS + 5; i++) begin
            tick();
            if (bus.out_valid) seen++;
        end
        chk("abort no output", seen, 0);
        set_ramp();
        for (int n = 0; n < 8; n++) begin
            start_in($sformatf("post_abort[%0d]", n), 0, (n == 0) ? 1 : 0);
            wait_out(0, lat);
            check_out($sformatf("post_abort[%0d]", n), n + 1, 0, 1'b0, lat);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
